// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP execution unit: op codes, FSM encoding and
// saturation limits of the accumulator.
package dsp_pkg;

   localparam int MUL_W_DEF = 16;
   localparam int ACC_W_DEF = 32;

   localparam logic [4:0] DSP_MAC    = 5'b00001;
   localparam logic [4:0] DSP_MUL    = 5'b00010;
   localparam logic [4:0] DSP_CLRACC = 5'b00011;
   localparam logic [4:0] DSP_RDACC  = 5'b00100;

   localparam logic [ACC_W_DEF-1:0] ACC_MAX = 32'h7FFF_FFFF;
   localparam logic [ACC_W_DEF-1:0] ACC_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } dsp_state_e;

endpackage

// File: rtl/dsp_seq_mult.sv
// Radix-2 shift-add multiplier on unsigned magnitudes; one partial product per
// cycle, with the last iteration's sum presented combinationally alongside o_done.
module dsp_seq_mult #(
   parameter int MUL_W = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [MUL_W-1:0]   i_mag_a,
   input  logic [MUL_W-1:0]   i_mag_b,
   output logic               o_done,
   output logic [2*MUL_W-1:0] o_product
);

   localparam int CNT_W = (MUL_W > 1) ? $clog2(MUL_W) : 1;

   logic               r_busy;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*MUL_W-1:0] r_mcand;
   logic [MUL_W-1:0]   r_mplier;
   logic [2*MUL_W-1:0] r_prod;

   logic [2*MUL_W-1:0] w_partial;
   logic [2*MUL_W-1:0] w_prod_next;
   logic               w_last;

   assign w_partial   = r_mplier[0] ? r_mcand : '0;
   assign w_prod_next = r_prod + w_partial;
   assign w_last      = (r_cnt == CNT_W'(MUL_W - 1));

   assign o_done    = r_busy && w_last;
   assign o_product = w_prod_next;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_mcand  <= (2*MUL_W)'(i_mag_a);
         r_mplier <= i_mag_b;
         r_prod   <= '0;
      end else if (r_busy) begin
         r_prod   <= w_prod_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (w_last) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/dsp_exec_unit.sv
// DSP execute-stage unit: saturating MAC/MUL accumulator around an iterative
// multiplier, with a stall line that freezes the pipeline while a multiply runs.
import dsp_pkg::*;

module dsp_exec_unit #(
   parameter int MUL_W = MUL_W_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_dsp_en,
   input  logic [4:0]       i_dsp_ctrl,
   input  logic [ACC_W-1:0] i_op_a,
   input  logic [ACC_W-1:0] i_op_b,
   output logic [ACC_W-1:0] o_dsp_result,
   output logic             o_dsp_valid,
   output logic             o_dsp_stall,
   output logic             o_acc_sat
);

   dsp_state_e r_state;
   dsp_state_e w_state_next;

   logic [ACC_W-1:0] r_acc;
   logic             r_sat;
   logic             r_is_mac;
   logic             r_neg;

   logic             w_is_mult_op;
   logic             w_mult_start;
   logic             w_mult_done;
   logic [2*MUL_W-1:0] w_mult_product;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [MUL_W-1:0] w_mag_a;
   logic [MUL_W-1:0] w_mag_b;

   logic [ACC_W-1:0] w_prod_ext;
   logic [ACC_W-1:0] w_prod_signed;
   logic [ACC_W-1:0] w_mac_sum;
   logic             w_ovf_pos;
   logic             w_ovf_neg;
   logic [ACC_W-1:0] w_mac_value;
   logic             w_unused_op_hi;

   assign w_unused_op_hi = ^{i_op_a[ACC_W-1:MUL_W], i_op_b[ACC_W-1:MUL_W]};

   assign w_is_mult_op = (i_dsp_ctrl == DSP_MAC) || (i_dsp_ctrl == DSP_MUL);

   // The most negative operand maps onto itself, which is its correct unsigned magnitude.
   assign w_a_neg = i_op_a[MUL_W-1];
   assign w_b_neg = i_op_b[MUL_W-1];
   assign w_mag_a = w_a_neg ? (~i_op_a[MUL_W-1:0] + 1'b1) : i_op_a[MUL_W-1:0];
   assign w_mag_b = w_b_neg ? (~i_op_b[MUL_W-1:0] + 1'b1) : i_op_b[MUL_W-1:0];

   dsp_seq_mult #(
      .MUL_W (MUL_W)
   ) u_mult (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_start   (w_mult_start),
      .i_mag_a   (w_mag_a),
      .i_mag_b   (w_mag_b),
      .o_done    (w_mult_done),
      .o_product (w_mult_product)
   );

   assign w_prod_ext    = ACC_W'(w_mult_product);
   assign w_prod_signed = r_neg ? (~w_prod_ext + 1'b1) : w_prod_ext;
   assign w_mac_sum     = r_acc + w_prod_signed;

   // Overflow is only possible when both addends share a sign the sum does not.
   assign w_ovf_pos = !r_acc[ACC_W-1] && !w_prod_signed[ACC_W-1] &&  w_mac_sum[ACC_W-1];
   assign w_ovf_neg =  r_acc[ACC_W-1] &&  w_prod_signed[ACC_W-1] && !w_mac_sum[ACC_W-1];
   assign w_mac_value = w_ovf_pos ? ACC_MAX : (w_ovf_neg ? ACC_MIN : w_mac_sum);

   assign o_acc_sat = r_sat;

   always_comb begin
      w_state_next = r_state;
      w_mult_start = 1'b0;
      o_dsp_valid  = 1'b0;
      o_dsp_stall  = 1'b0;
      o_dsp_result = '0;
      case (r_state)
         ST_IDLE: begin
            if (i_dsp_en) begin
               if (w_is_mult_op) begin
                  w_mult_start = 1'b1;
                  o_dsp_stall  = 1'b1;
                  w_state_next = ST_BUSY;
               end else begin
                  o_dsp_valid = 1'b1;
                  if (i_dsp_ctrl == DSP_RDACC) begin
                     o_dsp_result = r_acc;
                  end
               end
            end
         end
         ST_BUSY: begin
            o_dsp_stall = 1'b1;
            if (w_mult_done) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            o_dsp_valid  = 1'b1;
            o_dsp_result = r_acc;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= ST_IDLE;
         r_acc    <= '0;
         r_sat    <= 1'b0;
         r_is_mac <= 1'b0;
         r_neg    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_mult_start) begin
            r_is_mac <= (i_dsp_ctrl == DSP_MAC);
            r_neg    <= w_a_neg ^ w_b_neg;
         end
         if (r_state == ST_IDLE && i_dsp_en && i_dsp_ctrl == DSP_CLRACC) begin
            r_acc <= '0;
            r_sat <= 1'b0;
         end
         if (r_state == ST_BUSY && w_mult_done) begin
            if (r_is_mac) begin
               r_acc <= w_mac_value;
               if (w_ovf_pos || w_ovf_neg) begin
                  r_sat <= 1'b1;
               end
            end else begin
               r_acc <= w_prod_signed;
            end
         end
      end
   end

endmodule
